// File: rtl/ebi_pkg.sv
// Shared definitions for the EBI snoop arbiter: FSM state encoding, snoop
// opcode width and the cacheline beat-count helper.
package ebi_pkg;

  localparam int SNOOP_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  function automatic int beats_per_line(input int line_bits, input int beat_bits);
    return line_bits / beat_bits;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// searching upward with wrap. Produces a one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Walk candidates starting at ptr, keep the first one that is requesting
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/ebi_snoop_arbiter.sv
// Shares the EBI snoop request/response channel among NUM_REQ requesters,
// one snoop outstanding at a time. Optional response watchdog is enabled by
// defining EBI_SNP_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a requester; round-robin grant is offered combinationally
// ISSUE | buffered request presented to the EBI until it is accepted
// RESP  | response beats routed to the owner until the last beat (or timeout)
module ebi_snoop_arbiter
  import ebi_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int PADDR_WIDTH      = 32,
  parameter int DATA_WIDTH       = 64,
  parameter int CACHELINE_LENGTH = 512,
  parameter int TIMEOUT_CYCLES   = 1023
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_snvalid_i,
  output logic [NUM_REQ-1:0]             req_snready_o,
  input  logic [NUM_REQ*PADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*SNOOP_W-1:0]     req_snoop_i,
  output logic                           ebi_snvalid_o,
  input  logic                           ebi_snready_i,
  output logic [PADDR_WIDTH-1:0]         ebi_addr_o,
  output logic [SNOOP_W-1:0]             ebi_snoop_o,
  input  logic                           ebi_rsp_valid_i,
  output logic                           ebi_rsp_ready_o,
  input  logic                           ebi_rsp_has_data_i,
  input  logic [DATA_WIDTH-1:0]          ebi_rsp_data_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  input  logic [NUM_REQ-1:0]             rsp_ready_i,
  output logic                           rsp_has_data_o,
  output logic [DATA_WIDTH-1:0]          rsp_data_o,
  output logic [$clog2(NUM_REQ)-1:0]     owner_o,
  output logic                           busy_o
`ifdef EBI_SNP_ARB_TIMEOUT_EN
  ,
  output logic                           timeout_err_o
`endif
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int BEATS = beats_per_line(CACHELINE_LENGTH, DATA_WIDTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1 || BEATS < 1) begin : g_bad_cfg
    $error("ebi_snoop_arbiter: invalid parameterisation");
  end

  logic [1:0]             state;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          owner;
  logic [BW-1:0]          beat_cnt;
  logic [PADDR_WIDTH-1:0] buf_addr;
  logic [SNOOP_W-1:0]     buf_snoop;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [IW-1:0]          arb_idx;
  logic                   in_idle;
  logic                   in_resp;
  logic                   beat_xfer;
  logic                   last_beat;
  logic [IW-1:0]          next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_arbiter (
    .req (req_snvalid_i),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Handshake outputs are forced low during reset even if state is stale
  assign in_idle   = (state == ST_IDLE) && !rst;
  assign in_resp   = (state == ST_RESP) && !rst;
  assign beat_xfer = in_resp && ebi_rsp_valid_i && rsp_ready_i[owner];
  assign last_beat = !ebi_rsp_has_data_i || (beat_cnt == BW'(BEATS-1));
  assign next_ptr  = (owner == IW'(NUM_REQ-1)) ? '0 : owner + 1'b1;

  assign req_snready_o   = in_idle ? arb_gnt : '0;
  assign ebi_snvalid_o   = (state == ST_ISSUE) && !rst;
  assign ebi_addr_o      = buf_addr;
  assign ebi_snoop_o     = buf_snoop;
  assign ebi_rsp_ready_o = in_resp && rsp_ready_i[owner];
  assign rsp_has_data_o  = in_resp && ebi_rsp_has_data_i;
  assign rsp_data_o      = in_resp ? ebi_rsp_data_i : '0;
  assign owner_o         = owner;
  assign busy_o          = (state != ST_IDLE);

  // Route the response valid to the owning requester only
  always_comb begin
    rsp_valid_o = '0;
    if (in_resp && ebi_rsp_valid_i) rsp_valid_o[owner] = 1'b1;
  end

`ifdef EBI_SNP_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;
  logic            timeout_err;

  // Watchdog is a down-counter; terminal count on an idle RESP cycle trips it
  assign wd_expire     = in_resp && !beat_xfer && (wd_cnt == '0);
  assign timeout_err_o = timeout_err;

  // Reload on RESP entry and on every beat, count down on stalled RESP cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == ST_ISSUE && ebi_snready_i) || beat_xfer)
        wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
      else if (in_resp && wd_cnt != '0)
        wd_cnt <= wd_cnt - 1'b1;
      if (wd_expire) timeout_err <= 1'b1;
    end
  end
`else
  logic wd_expire;
  assign wd_expire = 1'b0;
`endif

  // Main sequencing FSM with request buffer and beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      buf_addr  <= '0;
      buf_snoop <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_snvalid_i) begin
            buf_addr  <= req_addr_i[arb_idx*PADDR_WIDTH +: PADDR_WIDTH];
            buf_snoop <= req_snoop_i[arb_idx*SNOOP_W +: SNOOP_W];
            owner     <= arb_idx;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ebi_snready_i) begin
            beat_cnt <= '0;
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (beat_xfer) begin
            if (last_beat) begin
              rr_ptr <= next_ptr;
              state  <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else if (wd_expire) begin
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
